// File: rtl/cpu_boot_loader.sv
// Boot-image loader: parses a LOAD/FILL/END command stream and drives a shared
// registered write bus into the CPU memories, holding the CPU in reset until END.
module cpu_boot_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int NUM_TGT = 4,
  parameter int CNT_W   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [NUM_TGT-1:0]  wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                cpu_rst,
  output logic                done,
  output logic                err,
  output logic [15:0]         words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL_DATA,
    S_FILL,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_FILL = 2'b01;
  localparam logic [1:0] CMD_END  = 2'b10;

  state_t              state_q, state_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [NUM_TGT-1:0]  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [15:0]         words_q, words_d;

  logic                ready;
  logic                accept;
  logic [1:0]          hdr_cmd;
  logic [1:0]          hdr_tgt;
  logic [CNT_W-1:0]    hdr_cnt;
  logic [15:0]         hdr_base;
  logic                hdr_tgt_bad;
  logic [NUM_TGT-1:0]  tgt_onehot;

  assign hdr_cmd     = s_data[31:30];
  assign hdr_tgt     = s_data[29:28];
  assign hdr_cnt     = s_data[27:16];
  assign hdr_base    = s_data[15:0];
  assign hdr_tgt_bad = (int'(hdr_tgt) >= NUM_TGT);
  assign tgt_onehot  = NUM_TGT'(4'b0001 << tgt_q);

  // Ready is forced low while rst is held so no word is consumed during reset.
  assign s_ready = ready & ~rst;
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    fill_d    = fill_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
    ready     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (accept) begin
          if (hdr_cmd == CMD_LOAD || hdr_cmd == CMD_FILL) begin
            if (hdr_tgt_bad) begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end else if (hdr_cnt != '0) begin
              tgt_d   = hdr_tgt;
              cnt_d   = hdr_cnt;
              addr_d  = ADDR_W'(hdr_base);
              state_d = (hdr_cmd == CMD_LOAD) ? S_LOAD : S_FILL_DATA;
            end
          end else if (hdr_cmd == CMD_END) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end

      S_LOAD: begin
        ready = 1'b1;
        if (accept) begin
          wr_en_d   = tgt_onehot;
          wr_addr_d = addr_q;
          wr_data_d = s_data;
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end

      S_FILL_DATA: begin
        ready = 1'b1;
        if (accept) begin
          fill_d  = s_data;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        wr_en_d   = tgt_onehot;
        wr_addr_d = addr_q;
        wr_data_d = fill_q;
        addr_d    = addr_q + ADDR_W'(1);
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end

      S_DONE:  ready = 1'b0;
      S_ERROR: ready = 1'b0;
      default: state_d = S_ERROR;
    endcase

    // Counted on the issuing edge so the counter tracks the visible pulses.
    words_d = words_q;
    if (wr_en_d != '0 && words_q != 16'hFFFF) words_d = words_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      fill_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      fill_q    <= fill_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      words_q   <= words_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign done          = done_q;
  assign cpu_rst       = ~done_q;
  assign err           = err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: default instance plus a NUM_TGT=3 instance
// used for the error-path scenarios.
module tb_cpu_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst, done, err;
  logic [15:0] words_written;

  logic        rst3;
  logic [31:0] s_data3;
  logic        s_valid3;
  logic        s_ready3;
  logic [2:0]  wr_en3;
  logic [15:0] wr_addr3;
  logic [31:0] wr_data3;
  logic        cpu_rst3, done3, err3;
  logic [15:0] words_written3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_boot_loader #(.DATA_W(32), .ADDR_W(16), .NUM_TGT(4), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_rst(cpu_rst),
    .done(done), .err(err), .words_written(words_written)
  );

  cpu_boot_loader #(.DATA_W(32), .ADDR_W(16), .NUM_TGT(3), .CNT_W(12)) dut3 (
    .clk(clk), .rst(rst3), .s_data(s_data3), .s_valid(s_valid3), .s_ready(s_ready3),
    .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .cpu_rst(cpu_rst3),
    .done(done3), .err(err3), .words_written(words_written3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    step(); step();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL rst_wr_en got=%b exp=0000", wr_en); end
    checks++; if (wr_addr !== 16'h0 || wr_data !== 32'h0) begin errors++; $display("FAIL rst_bus got=%h/%h exp=0/0", wr_addr, wr_data); end
    checks++; if ({cpu_rst, done, err} !== 3'b100) begin errors++; $display("FAIL rst_ctl got=%b exp=100", {cpu_rst, done, err}); end
    checks++; if (words_written !== 16'd0) begin errors++; $display("FAIL rst_words got=%0d exp=0", words_written); end
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL idle_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_load();
    logic [31:0] pay [3];
    pay[0] = 32'h80080000; pay[1] = 32'h80050001; pay[2] = 32'h01010200;
    s_valid = 1'b1; s_data = 32'h0003_0000;
    step();
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL load_hdr_wr_en got=%b exp=0000", wr_en); end
    for (int k = 0; k < 3; k++) begin
      s_data = pay[k];
      step();
      checks++;
      if (wr_en !== 4'b0001 || wr_addr !== 16'(k) || wr_data !== pay[k]) begin
        errors++; $display("FAIL load_wr%0d got=%b/%h/%h exp=0001/%h/%h", k, wr_en, wr_addr, wr_data, 16'(k), pay[k]);
      end
    end
    s_valid = 1'b0;
    step();
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL load_end_wr_en got=%b exp=0000", wr_en); end
    checks++; if (words_written !== 16'd3) begin errors++; $display("FAIL load_words got=%0d exp=3", words_written); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL load_cpu_rst got=%b exp=1", cpu_rst); end
  endtask

  task automatic test_fill();
    s_valid = 1'b1; s_data = 32'h6004_0008;
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_data_ready got=%b exp=1", s_ready); end
    s_data = 32'h0000_00FF;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_ready%0d got=%b exp=0", i, s_ready); end
      step();
      checks++;
      if (wr_en !== 4'b0100 || wr_addr !== 16'(8 + i) || wr_data !== 32'h0000_00FF) begin
        errors++; $display("FAIL fill_wr%0d got=%b/%h/%h exp=0100/%h/000000ff", i, wr_en, wr_addr, wr_data, 16'(8 + i));
      end
    end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after got=%b exp=1", s_ready); end
    step();
    checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL fill_extra_wr got=%b exp=0000", wr_en); end
    checks++; if (words_written !== 16'd7) begin errors++; $display("FAIL fill_words got=%0d exp=7", words_written); end
  endtask

  task automatic test_wrap_stall();
    s_valid = 1'b1; s_data = 32'h1002_FFFF;
    step();
    s_data = 32'hA5A5_0001;
    step();
    checks++;
    if (wr_en !== 4'b0010 || wr_addr !== 16'hFFFF || wr_data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL wrap_wr0 got=%b/%h/%h exp=0010/ffff/a5a50001", wr_en, wr_addr, wr_data);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (wr_en !== 4'b0000 || s_ready !== 1'b1) begin errors++; $display("FAIL stall%0d got=%b/%b exp=0000/1", i, wr_en, s_ready); end
    end
    s_valid = 1'b1; s_data = 32'h5A5A_0002;
    step();
    checks++;
    if (wr_en !== 4'b0010 || wr_addr !== 16'h0000 || wr_data !== 32'h5A5A_0002) begin
      errors++; $display("FAIL wrap_wr1 got=%b/%h/%h exp=0010/0000/5a5a0002", wr_en, wr_addr, wr_data);
    end
    s_valid = 1'b0;
    step();
    checks++; if (wr_en !== 4'b0000 || words_written !== 16'd9 || err !== 1'b0) begin errors++; $display("FAIL wrap_after got=%b/%0d/%b exp=0000/9/0", wr_en, words_written, err); end
  endtask

  task automatic test_end();
    s_valid = 1'b1; s_data = 32'h8000_0000;
    #1;
    checks++; if ({cpu_rst, done} !== 2'b10) begin errors++; $display("FAIL end_before got=%b exp=10", {cpu_rst, done}); end
    step();
    checks++; if ({cpu_rst, done} !== 2'b01) begin errors++; $display("FAIL end_release got=%b exp=01", {cpu_rst, done}); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL end_s_ready got=%b exp=0", s_ready); end
    s_data = 32'h0001_0000;
    step(); step();
    checks++; if (wr_en !== 4'b0000 || done !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL end_ignore got=%b/%b/%b exp=0000/1/0", wr_en, done, s_ready); end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b1; s_data = 32'h0005_0100;
    step();
    s_data = 32'h1111_0000;
    step();
    checks++; if (wr_en !== 4'b0001 || wr_addr !== 16'h0100) begin errors++; $display("FAIL mid_wr0 got=%b/%h exp=0001/0100", wr_en, wr_addr); end
    s_data = 32'h2222_0001; rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", s_ready); end
    step();
    checks++;
    if (wr_en !== 4'b0000 || wr_addr !== 16'h0 || wr_data !== 32'h0 || words_written !== 16'd0 ||
        {cpu_rst, done, err} !== 3'b100) begin
      errors++; $display("FAIL mid_rst_vals got=%b/%h/%h/%0d/%b exp=0000/0000/00000000/0/100",
                         wr_en, wr_addr, wr_data, words_written, {cpu_rst, done, err});
    end
    rst = 1'b0; s_data = 32'h3001_0020;
    step();
    s_data = 32'hDEAD_BEEF;
    step();
    s_valid = 1'b0;
    checks++;
    if (wr_en !== 4'b1000 || wr_addr !== 16'h0020 || wr_data !== 32'hDEAD_BEEF || words_written !== 16'd1) begin
      errors++; $display("FAIL mid_reload got=%b/%h/%h/%0d exp=1000/0020/deadbeef/1", wr_en, wr_addr, wr_data, words_written);
    end
  endtask

  task automatic test_error();
    rst3 = 1'b1; s_valid3 = 1'b0; s_data3 = '0;
    step(); rst3 = 1'b0;
    s_valid3 = 1'b1; s_data3 = 32'hC000_0000;
    step();
    checks++; if ({err3, s_ready3, cpu_rst3, done3} !== 4'b1010 || wr_en3 !== 3'b000) begin errors++; $display("FAIL err_cmd got=%b/%b exp=1010/000", {err3, s_ready3, cpu_rst3, done3}, wr_en3); end
    s_data3 = 32'h0001_0000;
    step(); step();
    checks++; if (err3 !== 1'b1 || wr_en3 !== 3'b000 || words_written3 !== 16'd0) begin errors++; $display("FAIL err_sticky got=%b/%b/%0d exp=1/000/0", err3, wr_en3, words_written3); end
    rst3 = 1'b1; s_valid3 = 1'b0;
    step();
    rst3 = 1'b0;
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err3); end
    s_valid3 = 1'b1; s_data3 = 32'h3001_0000;
    step();
    s_valid3 = 1'b0;
    checks++; if ({err3, s_ready3, cpu_rst3} !== 3'b101 || wr_en3 !== 3'b000) begin errors++; $display("FAIL err_tgt got=%b/%b exp=101/000", {err3, s_ready3, cpu_rst3}, wr_en3); end
    step();
    checks++; if (wr_en3 !== 3'b000 || err3 !== 1'b1) begin errors++; $display("FAIL err_tgt_nowr got=%b/%b exp=000/1", wr_en3, err3); end
  endtask

  initial begin
    rst3 = 1'b1; s_valid3 = 1'b0; s_data3 = '0;
    test_reset();
    test_load();
    test_fill();
    test_wrap_stall();
    test_end();
    test_reset_mid_load();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
